ps2_key_capture: RTL
====================

# ps2_key_capture

Receives the raw PS/2 keyboard clock/data lines, deframes 11-bit device-to-host frames and assembles the scan-code bytes of one keystroke into a 65-bit `ps2_key` word with a change-toggle bit. It is the producer side of the `ps2_key` interface consumed by the core's keyboard decoders. It lets a core take a physical PS/2 keyboard directly, in place of the HPS-supplied word.

## Interface
- `FILTER_LEN`, 8: number of consecutive equal clk_sys samples before a filtered line level changes.
- `TIMEOUT`, 100000: maximum clk_sys cycles between falling edges inside one frame (2 ms at 50 MHz).
- `clk_sys` in 1: system clock; one clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `ps2_clk_in` in 1: raw PS/2 clock line, asynchronous.
- `ps2_data_in` in 1: raw PS/2 data line, asynchronous.
- `ps2_key` out 65: bit [64] toggles once per completed keystroke; bits [63:0] hold the keystroke's bytes, most recent byte in [7:0].
- `frame_err` out 1: one-cycle pulse on a parity or stop-bit error.

## Operation
- Line conditioning:
  - Each input passes through a 2-FF synchronizer, then a filter.
  - The filtered level takes the new value only after FILTER_LEN consecutive identical synchronized samples.
  - An edge is detected when filtered clk goes 1→0.
- Frame FSM, advanced only on filtered falling edges:
  - IDLE: data 0 (start bit) → DATA with bit count 0. Data 1 → stay IDLE, no error.
  - DATA: shift data in LSB first. After the 8th bit → PARITY.
  - PARITY: latch the bit → STOP.
  - STOP: requires odd parity over the 8 data bits plus the parity bit, and stop bit = 1. If both hold, the byte is good. Otherwise pulse `frame_err` and clear the sequence assembler. Either way → IDLE.
  - Timeout: a counter clears on every falling edge. If it reaches TIMEOUT while in DATA, PARITY or STOP, the FSM returns to IDLE, discards the partial frame and raises no error.
- Sequence assembler (64-bit `seq`, 4-bit `cnt`). On each good byte b: `seq <= {seq[55:0], b}`, `cnt <= cnt+1`. The keystroke is incomplete when any of these holds:
  - b is E0 or F0;
  - `seq` ends in E0 12 (PrtScr make, first half);
  - `seq` ends in E0 F0 7C (PrtScr break, first half);
  - the first byte was E1 and fewer than 8 bytes have been collected.
- Otherwise the keystroke is complete:
  - `ps2_key[63:0] <= {seq[55:0], b}` and `ps2_key[64]` inverts;
  - `seq` and `cnt` clear.
- Overflow: an incomplete sequence that reaches 8 bytes is discarded (seq/cnt clear) with no toggle.
- `ps2_key[63:0]` holds its value between completions and changes only together with the toggle.

## Timing
- Reset values: `ps2_key` = 0 (toggle 0), `frame_err` = 0, FSM in IDLE, seq/cnt = 0, filtered lines = 1.
- Filter latency: FILTER_LEN + 2 cycles from a raw line change to the filtered change.
- Stop-bit edge detected in cycle N:
  - `frame_err` is high in cycle N+1 only;
  - on completion, `ps2_key` updates at the rising edge ending cycle N+1, so the new value is visible in cycle N+2.
- The toggle changes at most once per frame. Consumers compare against a registered copy of bit [64].
- An asserted `reset_n` mid-frame or mid-sequence discards everything immediately. The first frame after release must begin with a fresh start bit.
- A filtered falling edge coincident with timeout expiry is treated as a timeout: the FSM returns to IDLE and that edge is not used as a start bit.

## Structure
- Package `ps2_pkg`:
  - byte constants PS2_E0, PS2_F0, PS2_E1, PS2_PRT_MK (12), PS2_PRT_BRK (7C);
  - enum `ps2_frame_t` {IDLE, DATA, PARITY, STOP}.
- Sub-module `ps2_line_filter`, parameterised by FILTER_LEN, containing the synchronizer and filter. It is instantiated twice, once for clk and once for data.
- Frame FSM, timeout counter and sequence assembler are in the top module.

## Test plan
1. Frame 1C with correct parity → `ps2_key[64]` 0→1, `[63:0]`=0x1C, no `frame_err`.
2. Bytes E0, F0, 6B → exactly one toggle, `[23:0]`=E0F06B (decoder reads released and extended).
3. Byte 29 sent with wrong parity → `frame_err` high for exactly one cycle, toggle unchanged. A following good 29 → one toggle, `[15:0]`=0x0029.
4. PrtScr make E0 12 E0 7C → one toggle, `[31:0]`=E012E07C, `[63:32]`=0. Pause E1 14 77 E1 F0 14 F0 77 → one toggle, `[63:0]`=E11477E1F014F077.
5. Abandon a frame after 4 bits for > TIMEOUT cycles, then send a full 74 frame → one toggle, `[7:0]`=74. A clk glitch of FILTER_LEN−1 cycles produces no bit.
6. Assert `reset_n` low mid-frame after E0 was received, release, then send 1C → `ps2_key` was 0 during reset, then one toggle with `[15:0]`=0x001C (stale E0 gone).

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and frame-state type for the PS/2 keystroke capture block.
package ps2_pkg;

    localparam logic [7:0] PS2_E0      = 8'hE0;
    localparam logic [7:0] PS2_F0      = 8'hF0;
    localparam logic [7:0] PS2_E1      = 8'hE1;
    localparam logic [7:0] PS2_PRT_MK  = 8'h12;
    localparam logic [7:0] PS2_PRT_BRK = 8'h7C;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_frame_t;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus run-length filter for one raw PS/2 line.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic line_in,
    output logic line_out
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic [CW-1:0] run_q;

    // The filtered level flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            run_q   <= '0;
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
            if (sync2_q == filt_q) begin
                run_q <= '0;
            end else if (run_q == CW'(FILTER_LEN - 1)) begin
                filt_q <= sync2_q;
                run_q  <= '0;
            end else begin
                run_q <= run_q + 1'b1;
            end
        end
    end

    assign line_out = filt_q;

endmodule

// File: rtl/ps2_key_capture.sv
// PS/2 device-to-host deframer and keystroke assembler producing the 65-bit ps2_key word.
module ps2_key_capture
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [64:0] ps2_key,
    output logic        frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic clk_f;
    logic data_f;
    logic clk_f_prev_q;
    logic fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .line_in  (ps2_clk_in),
        .line_out (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .line_in  (ps2_data_in),
        .line_out (data_f)
    );

    assign fall = clk_f_prev_q & ~clk_f;

    ps2_frame_t     state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [TW-1:0]  tmo_q;
    logic           tmo_hit;
    logic           byte_ok_d, byte_ok_q;
    logic           err_d, err_q;
    logic [7:0]     byte_q;

    logic [63:0]    seq_q, seq_d, seq_n;
    logic [3:0]     cnt_q, cnt_d, cnt_n;
    logic           e1_q, e1_d, first_e1;
    logic           incomplete;
    logic [64:0]    key_q, key_d;

    // Expiry wins over a coincident edge so that edge cannot start a new frame.
    assign tmo_hit = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        byte_ok_d = 1'b0;
        err_d     = 1'b0;
        if (tmo_hit) begin
            state_d = IDLE;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!data_f) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {data_f, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = data_f;
                    state_d = STOP;
                end
                STOP: begin
                    if ((^{shift_q, par_q}) && data_f) byte_ok_d = 1'b1;
                    else                               err_d     = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_f_prev_q <= 1'b1;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            byte_ok_q    <= 1'b0;
            err_q        <= 1'b0;
            byte_q       <= '0;
        end else begin
            clk_f_prev_q <= clk_f;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            byte_ok_q    <= byte_ok_d;
            err_q        <= err_d;
            if (byte_ok_d) byte_q <= shift_q;
            if (fall)                         tmo_q <= '0;
            else if (tmo_q != TW'(TIMEOUT))   tmo_q <= tmo_q + 1'b1;
        end
    end

    always_comb begin
        seq_d      = seq_q;
        cnt_d      = cnt_q;
        e1_d       = e1_q;
        key_d      = key_q;
        seq_n      = {seq_q[55:0], byte_q};
        cnt_n      = cnt_q + 1'b1;
        first_e1   = (cnt_q == 4'd0) ? (byte_q == PS2_E1) : e1_q;
        incomplete = (byte_q == PS2_E0) || (byte_q == PS2_F0)
                   || (seq_n[15:0] == {PS2_E0, PS2_PRT_MK})
                   || (seq_n[23:0] == {PS2_E0, PS2_F0, PS2_PRT_BRK})
                   || (first_e1 && (cnt_n < 4'd8));
        if (err_q) begin
            seq_d = '0;
            cnt_d = '0;
            e1_d  = 1'b0;
        end else if (byte_ok_q) begin
            if (!incomplete) begin
                key_d = {~key_q[64], seq_n};
                seq_d = '0;
                cnt_d = '0;
                e1_d  = 1'b0;
            end else if (cnt_n == 4'd8) begin
                seq_d = '0;
                cnt_d = '0;
                e1_d  = 1'b0;
            end else begin
                seq_d = seq_n;
                cnt_d = cnt_n;
                e1_d  = first_e1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            seq_q <= '0;
            cnt_q <= '0;
            e1_q  <= 1'b0;
            key_q <= '0;
        end else begin
            seq_q <= seq_d;
            cnt_q <= cnt_d;
            e1_q  <= e1_d;
            key_q <= key_d;
        end
    end

    assign ps2_key   = key_q;
    assign frame_err = err_q;

endmodule
